alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALUOp/funct decoder. Merges ALU-control decode with a registered ALU datapath.
- Adds a valid/ready handshake, an iterative shift-add multiplier with HI/LO registers, shifts, sltu/xor, and an error flag for illegal decodes.
- Sits in the EX stage between the ID/EX register and the EX/MEM register. Stalls upstream through in_ready while a multiply is in flight.

---
 rtl/alu_exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with ALUOp/funct decode, valid/ready handshake,
// registered single-cycle results and an iterative signed/unsigned multiplier
// writing HI/LO. Illegal decodes produce result 0 with err set.
module alu_exec_unit #(
  parameter int WIDTH       = 32,
  parameter int SHW         = $clog2(WIDTH),
  parameter bit ENABLE_MULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FunCode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_SLL   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_SUB   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MULT  = 4'd10,
    ALU_MULTU = 4'd11,
    ALU_NOR   = 4'd12,
    ALU_MFHI  = 4'd13,
    ALU_MFLO  = 4'd14,
    ALU_ILL   = 4'd15
  } alu_ctl_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e               state_q;
  logic                 out_valid_q, zero_q, ovf_q, err_q, busy_q, neg_q;
  logic [WIDTH-1:0]     result_q, hi_q, lo_q, mplier_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [CW-1:0]        cnt_q;

  alu_ctl_e             ctl;
  logic [WIDTH-1:0]     alu_res, sum, diff, a_mag, b_mag;
  logic                 alu_ovf, is_mul, is_ill, accept;
  logic [2*WIDTH-1:0]   acc_step, prod;

  assign in_ready  = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign busy      = busy_q;

  // Decode ALUOp/FunCode into an internal ALU control code
  always_comb begin
    ctl = ALU_ILL;
    case (ALUOp)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (FunCode)
          6'd32:   ctl = ALU_ADD;
          6'd34:   ctl = ALU_SUB;
          6'd36:   ctl = ALU_AND;
          6'd37:   ctl = ALU_OR;
          6'd38:   ctl = ALU_XOR;
          6'd39:   ctl = ALU_NOR;
          6'd42:   ctl = ALU_SLT;
          6'd43:   ctl = ALU_SLTU;
          6'd0:    ctl = ALU_SLL;
          6'd2:    ctl = ALU_SRL;
          6'd3:    ctl = ALU_SRA;
          6'd24:   ctl = ENABLE_MULT ? ALU_MULT  : ALU_ILL;
          6'd25:   ctl = ENABLE_MULT ? ALU_MULTU : ALU_ILL;
          6'd16:   ctl = ENABLE_MULT ? ALU_MFHI  : ALU_ILL;
          6'd18:   ctl = ENABLE_MULT ? ALU_MFLO  : ALU_ILL;
          default: ctl = ALU_ILL;
        endcase
      end
      default: ctl = ALU_ILL;
    endcase
  end

  // Single-cycle datapath and multiplier operand conditioning
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctl)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:  alu_res = b << shamt;
      ALU_SRL:  alu_res = b >> shamt;
      ALU_SRA:  alu_res = $signed(b) >>> shamt;
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
    is_mul   = (ctl == ALU_MULT) || (ctl == ALU_MULTU);
    is_ill   = (ctl == ALU_ILL);
    a_mag    = ((ctl == ALU_MULT) && a[WIDTH-1]) ? -a : a;
    b_mag    = ((ctl == ALU_MULT) && b[WIDTH-1]) ? -b : b;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod     = neg_q ? -acc_q : acc_q;
  end

  // Control FSM, result registers, multiplier iteration and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q     <= S_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
              acc_q       <= '0;
              mcand_q     <= {{WIDTH{1'b0}}, a_mag};
              mplier_q    <= b_mag;
              neg_q       <= (ctl == ALU_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              err_q       <= is_ill;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          // WIDTH add/shift steps, then one extra cycle for sign fix-up and write-back
          if (cnt_q == CW'(WIDTH)) begin
            hi_q        <= prod[2*WIDTH-1:WIDTH];
            lo_q        <= prod[WIDTH-1:0];
            result_q    <= prod[WIDTH-1:0];
            zero_q      <= (prod[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: scoreboard of expected results pushed on accept and
// popped on consume, plus per-scenario inline checks of timing and flags.
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    ALUOp = 2'b00;
  logic [5:0]    FunCode = 6'd0;
  logic [4:0]    shamt = 5'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zero, overflow, err, busy;

  alu_exec_unit #(.WIDTH(W), .SHW(5), .ENABLE_MULT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .FunCode(FunCode), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         er;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [63:0]   mon_p;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;
  int            npass = 0;
  int            ntotal = 0;
  logic          rand_rdy = 1'b0;

  function automatic logic [63:0] mulprod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (sgn) p = longint'($signed(x)) * longint'($signed(y));
    else     p = {32'b0, x} * {32'b0, y};
    return p;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [5:0]  fe;
    logic [31:0] r, mask;
    logic [63:0] p;
    logic        ov, er;
    longint      s;
    r = '0; ov = 1'b0; er = 1'b0;
    if (op == 2'b00)      fe = 6'd32;
    else if (op == 2'b01) fe = 6'd34;
    else if (op == 2'b11) fe = 6'd63;
    else                  fe = f;
    case (fe)
      6'd32: begin s = longint'($signed(x)) + longint'($signed(y)); r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      6'd34: begin s = longint'($signed(x)) - longint'($signed(y)); r = s[31:0]; ov = (s > SMAX) || (s < SMIN); end
      6'd36: r = x & y;
      6'd37: r = x | y;
      6'd38: r = x ^ y;
      6'd39: r = ~(x | y);
      6'd42: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'd43: r = (x < y) ? 32'd1 : 32'd0;
      6'd0:  r = y << sh;
      6'd2:  r = y >> sh;
      6'd3:  begin mask = 32'hFFFF_FFFF >> sh; r = y >> sh; if (y[31]) r = r | ~mask; end
      6'd24: begin p = mulprod(1'b1, x, y); r = p[31:0]; end
      6'd25: begin p = mulprod(1'b0, x, y); r = p[31:0]; end
      6'd16: r = m_hi;
      6'd18: r = m_lo;
      default: er = 1'b1;
    endcase
    e.res = r; e.z = (r == 32'd0); e.ov = ov; e.er = er;
    return e;
  endfunction

  // Scoreboard: compare on consume, predict on accept (both judged for the coming edge)
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        ntotal++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected got res=%h with nothing expected", result);
        end else begin
          mon_e = sb.pop_front();
          if ({result, zero, overflow, err} !== mon_e)
            $display("FAIL sb_result got res=%h z=%b ov=%b err=%b expected res=%h z=%b ov=%b err=%b",
                     result, zero, overflow, err, mon_e.res, mon_e.z, mon_e.ov, mon_e.er);
          else npass++;
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(ALUOp, FunCode, shamt, a, b);
        if (ALUOp == 2'b10 && (FunCode == 6'd24 || FunCode == 6'd25)) begin
          mon_p = mulprod(FunCode == 6'd24, a, b);
          m_hi = mon_p[63:32];
          m_lo = mon_p[31:0];
        end
        sb.push_back(mon_e);
      end
    end
  end

  // Randomised consumer backpressure when enabled
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one op and hold until accepted; returns 1 time unit after the accept edge
  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y);
    int   n;
    logic acc;
    ALUOp = op; FunCode = f; shamt = sh; a = x; b = y; in_valid = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      ntotal++;
      $display("FAIL accept_timeout op=%b funct=%0d in_ready=%b required 1", op, f, in_ready);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    ntotal++;
    if ({in_ready, out_valid, result, zero, overflow, err, busy} !== '0)
      $display("FAIL reset_state got in_ready=%b vld=%b res=%h z=%b ov=%b err=%b busy=%b required all 0",
               in_ready, out_valid, result, zero, overflow, err, busy);
    else npass++;
    rst_n = 1'b1;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
    else npass++;
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    drive(2'b10, 6'd32, 5'd0, 32'd5, 32'd7);
    ntotal++;
    if ({out_valid, result, zero, overflow, err} !== {1'b1, 32'd12, 3'b000})
      $display("FAIL add_basic vld=%b res=%h z=%b ov=%b required 1/0000000c/0/0", out_valid, result, zero, overflow);
    else npass++;
    drive(2'b10, 6'd34, 5'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    ntotal++;
    if ({out_valid, result, zero, overflow} !== {1'b1, 32'h8000_0000, 2'b01})
      $display("FAIL sub_overflow vld=%b res=%h z=%b ov=%b required 1/80000000/0/1", out_valid, result, zero, overflow);
    else npass++;
    drive(2'b01, 6'd0, 5'd0, 32'd9, 32'd9);
    ntotal++;
    if ({out_valid, result, zero, overflow} !== {1'b1, 32'd0, 2'b10})
      $display("FAIL beq_zero vld=%b res=%h z=%b ov=%b required 1/00000000/1/0", out_valid, result, zero, overflow);
    else npass++;
    in_valid = 1'b0;
    step();
    ntotal++;
    if (out_valid !== 1'b0) $display("FAIL consume_no_accept out_valid=%b required 0", out_valid);
    else npass++;
  endtask

  task automatic test_mult();
    logic bad;
    int   n;
    out_ready = 1'b1;
    drive(2'b10, 6'd24, 5'd0, 32'hFFFF_FFFD, 32'd5);
    in_valid = 1'b1; ALUOp = 2'b10; FunCode = 6'd32;
    bad = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      step();
    end
    in_valid = 1'b0;
    ntotal++;
    if (bad || busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mult_busy_window bad=%b busy=%b vld=%b required busy held, no output for %0d cycles", bad, busy, out_valid, W);
    else npass++;
    step();
    ntotal++;
    if ({out_valid, busy, in_ready, result} !== {3'b100, 32'hFFFF_FFF1})
      $display("FAIL mult_latency vld=%b busy=%b in_ready=%b res=%h required 1/0/0/fffffff1", out_valid, busy, in_ready, result);
    else npass++;
    drive(2'b10, 6'd16, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if (result !== 32'hFFFF_FFFF) $display("FAIL mfhi_signed res=%h required ffffffff", result);
    else npass++;
    drive(2'b10, 6'd25, 5'd0, 32'hFFFF_FFFF, 32'd2);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    ntotal++;
    if (n != W + 1 || result !== 32'hFFFF_FFFE)
      $display("FAIL multu_lo cycles=%0d res=%h required %0d/fffffffe", n, result, W + 1);
    else npass++;
    drive(2'b10, 6'd16, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if (result !== 32'd1) $display("FAIL mfhi_unsigned res=%h required 00000001", result);
    else npass++;
    drive(2'b10, 6'd18, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if (result !== 32'hFFFF_FFFE) $display("FAIL mflo_unsigned res=%h required fffffffe", result);
    else npass++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic bad;
    out_ready = 1'b0;
    drive(2'b10, 6'd32, 5'd0, 32'd3, 32'd4);
    ALUOp = 2'b10; FunCode = 6'd32; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, result, zero, overflow, err, in_ready} !== {1'b1, 32'd7, 4'b0000}) bad = 1'b1;
      step();
    end
    ntotal++;
    if (bad) $display("FAIL backpressure_hold vld=%b res=%h in_ready=%b required 1/00000007/0 held", out_valid, result, in_ready);
    else npass++;
    out_ready = 1'b1;
    @(negedge clk);
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL release_ready in_ready=%b required 1", in_ready);
    else npass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ntotal++;
    if ({out_valid, result} !== {1'b1, 32'd30})
      $display("FAIL consume_and_accept vld=%b res=%h required 1/0000001e", out_valid, result);
    else npass++;
    step();
  endtask

  task automatic test_shift_err();
    out_ready = 1'b1;
    drive(2'b10, 6'd3, 5'd4, 32'd0, 32'h8000_0000);
    ntotal++;
    if (result !== 32'hF800_0000) $display("FAIL sra res=%h required f8000000", result);
    else npass++;
    drive(2'b10, 6'd2, 5'd4, 32'd0, 32'h8000_0000);
    ntotal++;
    if (result !== 32'h0800_0000) $display("FAIL srl res=%h required 08000000", result);
    else npass++;
    drive(2'b10, 6'd0, 5'd31, 32'd0, 32'd1);
    ntotal++;
    if (result !== 32'h8000_0000) $display("FAIL sll_max res=%h required 80000000", result);
    else npass++;
    drive(2'b10, 6'd3, 5'd0, 32'd0, 32'hA5A5_A5A5);
    ntotal++;
    if (result !== 32'hA5A5_A5A5) $display("FAIL shamt_zero res=%h required a5a5a5a5", result);
    else npass++;
    drive(2'b10, 6'd63, 5'd0, 32'd5, 32'd7);
    ntotal++;
    if ({out_valid, result, overflow, err} !== {1'b1, 32'd0, 2'b01})
      $display("FAIL illegal_funct vld=%b res=%h ov=%b err=%b required 1/00000000/0/1", out_valid, result, overflow, err);
    else npass++;
    drive(2'b11, 6'd32, 5'd0, 32'h7FFF_FFFF, 32'd1);
    ntotal++;
    if ({out_valid, result, overflow, err} !== {1'b1, 32'd0, 2'b01})
      $display("FAIL illegal_aluop vld=%b res=%h ov=%b err=%b required 1/00000000/0/1", out_valid, result, overflow, err);
    else npass++;
    drive(2'b10, 6'd16, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if ({result, err} !== {32'd1, 1'b0}) $display("FAIL hi_untouched res=%h err=%b required 00000001/0", result, err);
    else npass++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int fl [11] = '{32, 34, 36, 37, 38, 39, 42, 43, 0, 2, 3};
    logic bad;
    logic [31:0] x, y;
    int k;
    out_ready = 1'b1;
    bad = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(2'b00, 6'd0, 5'd0, 32'd100, 32'(i));
      if ({out_valid, result} !== {1'b1, 32'(100 + i)}) bad = 1'b1;
    end
    ntotal++;
    if (bad) $display("FAIL b2b_adds vld=%b res=%h required one result per cycle", out_valid, result);
    else npass++;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 10);
      x = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      y = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
      drive(($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10, 6'(fl[k]), 5'($urandom), x, y);
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (3) step();
    ntotal++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL b2b_drain pending=%0d vld=%b required 0/0", sb.size(), out_valid);
    else npass++;
  endtask

  task automatic test_reset_mid_mult();
    out_ready = 1'b1;
    drive(2'b10, 6'd24, 5'd0, 32'h1234_5678, 32'h0000_9ABC);
    in_valid = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    ntotal++;
    if ({in_ready, out_valid, result, zero, overflow, err, busy} !== '0)
      $display("FAIL reset_mid_mult in_ready=%b vld=%b res=%h z=%b ov=%b err=%b busy=%b required all 0",
               in_ready, out_valid, result, zero, overflow, err, busy);
    else npass++;
    step();
    rst_n = 1'b1;
    step();
    drive(2'b10, 6'd18, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if ({out_valid, result, zero} !== {1'b1, 32'd0, 1'b1})
      $display("FAIL mflo_after_reset vld=%b res=%h z=%b required 1/00000000/1", out_valid, result, zero);
    else npass++;
    drive(2'b10, 6'd16, 5'd0, 32'd0, 32'd0);
    ntotal++;
    if (result !== 32'd0) $display("FAIL mfhi_after_reset res=%h required 00000000", result);
    else npass++;
    in_valid = 1'b0;
    repeat (2) step();
    ntotal++;
    if (sb.size() != 0) $display("FAIL final_drain pending=%0d required 0", sb.size());
    else npass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mult();
    test_backpressure();
    test_shift_err();
    test_back_to_back();
    test_reset_mid_mult();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
